// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: sequencer states and register-file constants.
package exec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_WB,
        S_DONE
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_IDX     = 4'd15;

endpackage

// File: rtl/lowest_set16.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit vector.
module lowest_set16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);

    // Scan downward so the lowest set bit is the last assignment and wins.
    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
    end

    assign valid = |vec;

endmodule

// File: rtl/ldm_writer.sv
// Load-multiple write sequencer: reads one word per listed register and writes
// each into the register file, lowest index at lowest address, then optional base writeback.
module ldm_writer
    import exec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              up,
    input  logic              wback,
    input  logic [3:0]        base_reg,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_en,
    output logic [3:0]        sel_in,
    output logic [DATA_W-1:0] in_reg,
    output logic              pc_written
);

    state_t            state, state_nxt;
    logic [15:0]       list_rem, list_orig, list_after;
    logic [ADDR_W-1:0] addr, addr_final;
    logic [DATA_W-1:0] data;
    logic              wback_r;
    logic [3:0]        base_r;

    logic [4:0]        n;
    logic [ADDR_W-1:0] span, base_al, start_addr, final_addr;
    logic [3:0]        low_idx;
    logic              low_vld;

    always_comb begin
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(reg_list[i]);
    end

    // Both IA and DB walk upward from the lowest address, so DB starts at base - 4n.
    assign span       = ADDR_W'(n) * ADDR_W'(WORD_BYTES);
    assign base_al    = {base_addr[ADDR_W-1:2], 2'b00};
    assign start_addr = up ? base_al : base_al - span;
    assign final_addr = up ? base_al + span : base_al - span;

    lowest_set16 u_low (
        .vec   (list_rem),
        .idx   (low_idx),
        .valid (low_vld)
    );

    assign list_after = list_rem & ~(16'd1 << low_idx);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        wr_en     = 1'b0;
        sel_in    = '0;
        in_reg    = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (reg_list != 16'd0) ? S_REQ : S_DONE;
            end
            S_REQ: begin
                mem_req  = 1'b1;
                mem_addr = addr;
                if (mem_ack) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                wr_en  = low_vld;
                sel_in = low_idx;
                in_reg = data;
                if (list_after != 16'd0)                 state_nxt = S_REQ;
                else if (wback_r && !list_orig[base_r]) state_nxt = S_WB;
                else                                     state_nxt = S_DONE;
            end
            S_WB: begin
                wr_en     = 1'b1;
                sel_in    = base_r;
                in_reg    = DATA_W'(addr_final);
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign pc_written = wr_en && (sel_in == PC_IDX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            list_rem   <= '0;
            list_orig  <= '0;
            addr       <= '0;
            addr_final <= '0;
            data       <= '0;
            wback_r    <= 1'b0;
            base_r     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    list_rem   <= reg_list;
                    list_orig  <= reg_list;
                    addr       <= start_addr;
                    addr_final <= final_addr;
                    wback_r    <= wback;
                    base_r     <= base_reg;
                end
                S_REQ: if (mem_ack) begin
                    data <= mem_rdata;
                    addr <= addr + ADDR_W'(WORD_BYTES);
                end
                S_WRITE: list_rem <= list_after;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_writer.sv
// Scoreboard bench for ldm_writer: expected reads/writes queued at start, checked as the DUT produces them.
module tb_ldm_writer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic [31:0] base_addr = '0;
    logic        up = 1'b0;
    logic        wback = 1'b0;
    logic [3:0]  base_reg = '0;
    logic        busy, done, mem_req, wr_en, pc_written;
    logic [31:0] mem_addr, in_reg;
    logic [3:0]  sel_in;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    ldm_writer #(.DATA_W(32), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .up         (up),
        .wback      (wback),
        .base_reg   (base_reg),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wr_en      (wr_en),
        .sel_in     (sel_in),
        .in_reg     (in_reg),
        .pc_written (pc_written)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int delay = 0, wait_cnt = 0, busy_cnt = 0, done_cnt = 0;
    bit mon_en = 1'b0, held = 1'b0;
    logic [31:0] hold_addr;
    logic [35:0] wexp;
    logic [31:0] exp_addr[$];
    logic [35:0] exp_wr[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: data = addr ^ 0xFFFF0000, ack after `delay` wait cycles.
    always @(posedge clock) begin
        #1;
        mem_ack   = mem_req && (wait_cnt >= delay);
        mem_rdata = mem_addr ^ 32'hFFFF0000;
    end

    always @(negedge clock) begin
        if (mem_req && !mem_ack) wait_cnt++;
        else                     wait_cnt = 0;
        if (mon_en) begin
            if (mem_req) begin
                if (held)                   chk("addr_hold", mem_addr, hold_addr);
                else if (exp_addr.size() != 0) chk("rd_addr", mem_addr, exp_addr.pop_front());
                else                        chk("rd_extra", 1, 0);
                held      = !mem_ack;
                hold_addr = mem_addr;
                chk("req_wr_excl", wr_en, 0);
            end else begin
                held = 1'b0;
            end
            if (wr_en) begin
                if (exp_wr.size() != 0) begin
                    wexp = exp_wr.pop_front();
                    chk("wr_sel", sel_in, wexp[35:32]);
                    chk("wr_data", in_reg, wexp[31:0]);
                    chk("pc_written", pc_written, wexp[35:32] == 4'd15);
                end else begin
                    chk("wr_extra", 1, 0);
                end
            end else if (pc_written) begin
                chk("pc_spurious", 1, 0);
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start(input logic [15:0] lst, input logic [31:0] base,
                               input logic u, input logic wb, input logic [3:0] br);
        @(negedge clock); #1;
        start = 1'b1; reg_list = lst; base_addr = base; up = u; wback = wb; base_reg = br;
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run(input string nm, input logic [15:0] lst, input logic [31:0] base,
                       input logic u, input logic wb, input logic [3:0] br,
                       input int dly, input bit mid);
        int n, expb;
        logic [31:0] a, fin;
        bit got_done;
        n   = $countones(lst);
        a   = {base[31:2], 2'b00};
        fin = u ? a + 32'(4 * n) : a - 32'(4 * n);
        if (!u) a = fin;
        for (int i = 0; i < 16; i++) begin
            if (lst[i]) begin
                exp_addr.push_back(a);
                exp_wr.push_back({4'(i), a ^ 32'hFFFF0000});
                a = a + 32'd4;
            end
        end
        expb = (2 + dly) * n + 1;
        if (lst != 16'd0 && wb && !lst[br]) begin
            exp_wr.push_back({br, fin});
            expb++;
        end
        delay = dly; busy_cnt = 0; done_cnt = 0; held = 1'b0;
        pulse_start(lst, base, u, wb, br);
        got_done = 1'b0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            @(negedge clock); #1;
            start = 1'b0;
            if (done_cnt != 0) got_done = 1'b1;
            else if (mid && c == 3) begin
                start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h0; base_reg = 4'd3;
            end
        end
        chk({nm, "_done_seen"}, got_done, 1);
        @(negedge clock); #1;
        chk({nm, "_busy_after"}, busy, 0);
        chk({nm, "_busy_cycles"}, busy_cnt, expb);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_rd_left"}, exp_addr.size(), 0);
        chk({nm, "_wr_left"}, exp_wr.size(), 0);
        exp_addr.delete();
        exp_wr.delete();
    endtask

    initial begin
        int reqs, bad;
        bit prev;
        logic [15:0] rl;
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_wr", wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_sel", sel_in, 0);
        chk("rst_in", in_reg, 0);
        chk("rst_pc", pc_written, 0);
        @(negedge clock); #1 reset_n = 1'b1;
        mon_en = 1'b1;

        run("ia_wb",    16'h0003, 32'h0000_0100, 1'b1, 1'b1, 4'd2, 0, 1'b0);
        run("db_pc",    16'h8010, 32'h0000_0200, 1'b0, 1'b0, 4'd0, 0, 1'b0);
        run("base_in",  16'h0006, 32'h0000_0300, 1'b1, 1'b1, 4'd1, 0, 1'b0);
        run("slow_ack", 16'h0003, 32'h0000_0400, 1'b1, 1'b1, 4'd2, 3, 1'b1);
        run("empty",    16'h0000, 32'h0000_0500, 1'b1, 1'b1, 4'd2, 0, 1'b0);
        run("wrap_db",  16'h0001, 32'h0000_0002, 1'b0, 1'b1, 4'd5, 0, 1'b0);
        run("wrap_ia",  16'h0003, 32'hFFFF_FFFD, 1'b1, 1'b1, 4'd15, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rl = 16'($urandom_range(1, 16'hFFFF));
            run("rand", rl, $urandom, 1'($urandom), 1'($urandom), 4'($urandom),
                int'($urandom_range(0, 2)), 1'b0);
        end

        // Abort during the second read request.
        mon_en = 1'b0; delay = 0;
        pulse_start(16'h0003, 32'h0000_0100, 1'b1, 1'b1, 4'd2);
        reqs = mem_req ? 1 : 0;
        prev = mem_req;
        for (int c = 0; c < 50 && reqs < 2; c++) begin
            @(negedge clock); #1;
            if (mem_req && !prev) reqs++;
            prev = mem_req;
        end
        chk("abort_second_req", reqs, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_req", mem_req, 0);
        chk("abort_wr", wr_en, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_sel", sel_in, 0);
        chk("abort_in", in_reg, 0);
        chk("abort_pc", pc_written, 0);
        bad = 0;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (mem_req || wr_en || done) bad++;
        end
        chk("abort_quiet", bad, 0);
        mon_en = 1'b1;
        run("after_rst", 16'h0101, 32'h0000_0800, 1'b0, 1'b1, 4'd7, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldm_writer.md
# ldm_writer

Load-multiple write sequencer for the execute stage. Takes a 16-bit register list and a base address and fetches one word per listed register over a req/ack memory port. Each returned word is written into the register file through its single write port (`sel_in`/`in_reg`), followed by an optional base-register writeback. It is the writing end of the register file interface, whose read end is `p0`/`p1`/`pc_out`.

## Interface
Parameters:
- `DATA_W`, 32, data word width.
- `ADDR_W`, 32, byte address width.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- `reg_list`  in  16  bit i set = load r_i; sampled with `start`.
- `base_addr`  in  ADDR_W  base byte address; sampled with `start`.
- `up`  in  1  1 = increment-after (IA), 0 = decrement-before (DB); sampled with `start`.
- `wback`  in  1  write the final address to `base_reg`; sampled with `start`.
- `base_reg`  in  4  base register index; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE ends.
- `done`  out  1  one-cycle pulse in DONE.
- `mem_req`  out  1  read request, held until `mem_ack`.
- `mem_addr`  out  ADDR_W  word-aligned read address; `[1:0]` is always 00.
- `mem_ack`  in  1  read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  DATA_W  read data.
- `wr_en`  out  1  register file write strobe.
- `sel_in`  out  4  register file write index.
- `in_reg`  out  DATA_W  register file write data.
- `pc_written`  out  1  pulse coincident with a write to r15; used for fetch flush.

## Operation
- States: IDLE, REQ, WRITE, WB, DONE.
- IDLE:
  - `start` with `reg_list`≠0 latches all inputs and computes n = popcount(`reg_list`).
  - The start address is `base_addr` (IA) or `base_addr` − 4n (DB).
  - The final address is `base_addr` + 4n (IA) or `base_addr` − 4n (DB).
  - Next state is REQ.
- IDLE, empty list: `start` with `reg_list`=0 goes straight to DONE. No memory access and no writeback.
- REQ:
  - `mem_req`=1 and `mem_addr`=current address, both stable until ack.
  - On `mem_ack`, capture `mem_rdata`, advance the address by +4, go to WRITE.
- WRITE:
  - `wr_en`=1, `sel_in`=lowest set bit of the remaining list, `in_reg`=captured word. Clear that bit.
  - If the remaining list is still nonzero, go to REQ.
  - Otherwise go to WB if `wback` is set and `base_reg` is not in the original list, else go to DONE.
- Register ordering: registers are always loaded lowest index first at the lowest address, in both IA and DB.
- WB: `wr_en`=1, `sel_in`=`base_reg`, `in_reg`=final address, then go to DONE.
- Base in list: if `base_reg` is in the list, the loaded value wins and WB is skipped.
- DONE: `done`=1 for one cycle, then IDLE. `busy` is low in the cycle after DONE.
- `start` outside IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_W (wraps silently). `base_addr[1:0]` is ignored.
- `pc_written` = `wr_en` && `sel_in`==15, in both WRITE and WB.

## Timing
- Reset (async assert, sync release): state=IDLE, and `busy`, `done`, `mem_req`, `wr_en`, `pc_written`=0. `mem_addr`, `sel_in`, `in_reg`=0.
- Reset mid-transfer aborts immediately. No further `mem_req` or `wr_en`, and no `done`.
- With zero-wait ack, each register costs 2 cycles (REQ then WRITE).
- A transfer of n registers with zero-wait ack takes 2n + [1 if WB] + 1 cycles from the first `busy` cycle to the end of DONE.
- Every extra cycle without `mem_ack` holds REQ for one more cycle.
- At most one `wr_en` per cycle. The register file sees a write on the clock edge that ends WRITE or WB.
- `mem_req` is never asserted in the same cycle as `wr_en`.

## Structure
- Shared package `exec_pkg`:
  - state enum/localparams for IDLE, REQ, WRITE, WB, DONE;
  - `WORD_BYTES`=4;
  - `PC_IDX`=15.
- Sub-module `lowest_set16`: combinational priority encoder returning index and valid.
- Popcount for n is inline in `ldm_writer`.

## Test plan
- `reg_list`=16'h0003, `base_addr`=0x100, `up`=1, `wback`=1, `base_reg`=2, zero-wait memory returning addr^0xFFFF0000:
  - writes r0=0xFFFF0100, then r1=0xFFFF0104, then r2=0x108;
  - `done` 6 cycles after `busy` rises.
- DB, `reg_list`=16'h8010, `base_addr`=0x200, `wback`=0:
  - reads 0x1F8, then 0x1FC;
  - writes r4, then r15;
  - `pc_written` is pulsed only on the r15 write.
- `base_reg`=1 with r1 in the list and `wback`=1: r1 gets the memory word, and no WB write occurs.
- `mem_ack` delayed 3 cycles per read: `mem_req`/`mem_addr` are held stable; a `start` pulsed mid-transfer is ignored.
- `reg_list`=0: `done` one cycle after `busy`, no `mem_req`, no `wr_en`.
- `reset_n` dropped during the second REQ: all outputs go to 0 asynchronously, and no `done` ever follows.
